acumulador_sumando: RTL and testbench
=====================================

Name: acumulador_sumando

Overview:
Up-counting accumulator: the counterpart to the team's down-counting accumulator. It starts from zero, adds a step on each qualified `add` pulse, and flags when a latched target is reached. It is used wherever a block must count events up to a programmable limit, e.g. bit or sample counters in the serial and timing blocks. A small start/done FSM frames each counting run.

Parameters:
REG_WIDTH, 8, width of accumulator, target and step.
ADD_VALUE, 1, fixed increment per `add` pulse (used when ACUM_STEP_EN is not defined); must satisfy 1 <= ADD_VALUE < 2^REG_WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  begin a new run; sampled on rising clk
target  input  REG_WIDTH  terminal count, latched on accepted start
add  input  1  increment request, one step per cycle high
N  output  REG_WIDTH  current accumulator value (registered)
busy  output  1  high while in RUN
out_K  output  1  high while in DONE (target reached)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, N=0, latched target T=0, busy=0, out_K=0. All outputs are registered, and reset overrides everything, including mid-run.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 -> T<=target, N<=0.
  - Next state is RUN if target!=0, else DONE.
  - `add` is ignored.
- RUN: busy=1, out_K=0.
  - If add=1, the sum S = N + step is computed in REG_WIDTH+1 bits. This makes overflow impossible to misjudge.
  - If S >= T: N<=T (saturate at target, never overshoot), next state DONE.
  - Else: N<=S[REG_WIDTH-1:0], stay RUN.
  - If add=0: N holds.
  - start=1 in RUN restarts the run, with the same action as in IDLE. start takes priority over a simultaneous add.
- DONE: busy=0, out_K=1, N holds T.
  - `add` is ignored (no wrap, no further change).
  - start=1 -> restart exactly as from IDLE. With target=0 the block re-enters DONE, and out_K stays 1 with no gap.
  - start=0 -> stay DONE indefinitely.
- Latency:
  - out_K rises on the clock edge that captures the final add, i.e. visible the cycle after that add.
  - With start and target=0: out_K is visible the cycle after start.
- `target` changes while busy have no effect; only the latched T is used.
- step = ADD_VALUE (or the `step` port when the optional feature is enabled).

Optional Feature:
Macro ACUM_STEP_EN.
- Defined:
  - Adds input port `step [REG_WIDTH-1:0]`, sampled each cycle `add` is high; ADD_VALUE is unused.
  - step=0 with add=1 leaves N unchanged and stays in RUN, except that if T is reached via the S>=T rule it moves to DONE.
- Not defined: no `step` port; the increment is the constant ADD_VALUE.

Test Plan:
1. Reset mid-run: start with target=5, 2 adds, then assert rst=0 asynchronously between edges -> N=0, busy=0, out_K=0 immediately, without waiting for a clock edge.
2. Basic count, REG_WIDTH=8, ADD_VALUE=1: start with target=3, then 3 single-cycle adds -> N goes 1,2,3; out_K=1 and busy=0 the cycle after the 3rd add; a 4th add leaves N=3.
3. Saturation, ADD_VALUE=4: start with target=10 -> N goes 4,8, then 10 (not 12), and state is DONE.
4. Overflow boundary, ADD_VALUE=1: start with target=255, add held high for 300 cycles -> N reaches 255, out_K=1, and N never wraps to 0.
5. Zero target and restart: start with target=0 -> out_K=1 the next cycle, N=0. Then start with target=2 -> busy=1, out_K=0, N=0.
6. Priority: in RUN with N=2, assert start (target=7) and add in the same cycle -> N=0, T=7, state RUN. With ACUM_STEP_EN defined, step=3 on 3 adds gives N = 3, 6, 7, and out_K=1.

Source files
------------

// File: rtl/acumulador_sumando.sv
`default_nettype none
// ============================================================================
// Module      : acumulador_sumando
// Description : Up-counting accumulator with a start/done framing FSM.
//               Counts from zero in fixed (or port-supplied) steps on each
//               qualified add, saturating at a target latched on start.
//               Optional feature macro: ACUM_STEP_EN (adds a `step` input
//               port that replaces the constant ADD_VALUE increment).
// Revision    : 1.0 - initial release
// ============================================================================
module acumulador_sumando #(
  parameter int REG_WIDTH = 8,
  parameter int ADD_VALUE = 1
) (
  input  logic                 clk,
  input  logic                 rst,      // asynchronous, active-low
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] target,
  input  logic                 add,
`ifdef ACUM_STEP_EN
  input  logic [REG_WIDTH-1:0] step,
`endif
  output logic [REG_WIDTH-1:0] N,
  output logic                 busy,
  output logic                 out_K
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [REG_WIDTH-1:0] n_q, n_d;
  logic [REG_WIDTH-1:0] t_q, t_d;
  logic                 busy_q, busy_d;
  logic                 out_k_q, out_k_d;

  logic [REG_WIDTH-1:0] step_w;
  logic [REG_WIDTH:0]   sum_w;
  logic                 reach_w;

  // Select the increment source: the external port or the fixed constant.
`ifdef ACUM_STEP_EN
  assign step_w = step;
`else
  assign step_w = REG_WIDTH'(ADD_VALUE);
`endif

  // Sum carried one bit wider so a carry-out still compares correctly with T.
  assign sum_w   = {1'b0, n_q} + {1'b0, step_w};
  assign reach_w = (sum_w >= {1'b0, t_q});

  // Next-state, accumulator and registered-output computation.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    t_d     = t_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          t_d     = target;
          n_d     = '0;
          state_d = (target != '0) ? ST_RUN : ST_DONE;
        end
      end

      ST_RUN: begin
        // A restart wins over an add arriving in the same cycle.
        if (start) begin
          t_d     = target;
          n_d     = '0;
          state_d = (target != '0) ? ST_RUN : ST_DONE;
        end else if (add) begin
          if (reach_w) begin
            n_d     = t_q;   // saturate at the target, never overshoot
            state_d = ST_DONE;
          end else begin
            n_d     = sum_w[REG_WIDTH-1:0];
          end
        end
      end

      ST_DONE: begin
        // Further adds are ignored; only a new start leaves DONE.
        if (start) begin
          t_d     = target;
          n_d     = '0;
          state_d = (target != '0) ? ST_RUN : ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        n_d     = '0;
        t_d     = '0;
      end
    endcase

    // Status flags follow the state being entered so they are registered.
    busy_d  = (state_d == ST_RUN);
    out_k_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      t_q     <= '0;
      busy_q  <= 1'b0;
      out_k_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      out_k_q <= out_k_d;
    end
  end

  assign N     = n_q;
  assign busy  = busy_q;
  assign out_K = out_k_q;

endmodule
`default_nettype wire

// File: tb/tb_acumulador_sumando.sv
`default_nettype none
// ============================================================================
// Module      : tb_acumulador_sumando
// Description : Scoreboard bench for acumulador_sumando. Two instances run in
//               parallel (ADD_VALUE=1 and ADD_VALUE=4) from shared stimulus;
//               a behavioural model queues expected outputs and monitor
//               processes pop and compare them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acumulador_sumando;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] target;
  logic       add;
  logic [7:0] step_drv;
  logic [7:0] n1, n4;
  logic       busy1, busy4, k1, k4;

  acumulador_sumando #(.REG_WIDTH(8), .ADD_VALUE(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .add    (add),
`ifdef ACUM_STEP_EN
    .step   (step_drv),
`endif
    .N      (n1),
    .busy   (busy1),
    .out_K  (k1)
  );

  acumulador_sumando #(.REG_WIDTH(8), .ADD_VALUE(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .add    (add),
`ifdef ACUM_STEP_EN
    .step   (step_drv),
`endif
    .N      (n4),
    .busy   (busy4),
    .out_K  (k4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] n0;
    logic [7:0] n1;
    logic       b0;
    logic       b1;
    logic       k0;
    logic       k1;
  } item_t;

  item_t q[$];
  item_t aq[$];
  event  ev_async;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  // Reference model: plain integers, one slot per instance.
  int m_n[2];
  int m_t[2];
  bit m_run[2];
  bit m_done[2];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cycle_no, got, exp);
    end
  endtask

  task automatic compare_item(input item_t it);
    check("N_add1",     int'(n1),    int'(it.n0));
    check("busy_add1",  int'(busy1), int'(it.b0));
    check("outK_add1",  int'(k1),    int'(it.k0));
    check("N_add4",     int'(n4),    int'(it.n1));
    check("busy_add4",  int'(busy4), int'(it.b1));
    check("outK_add4",  int'(k4),    int'(it.k1));
  endtask

  function automatic item_t snapshot();
    item_t it;
    it.n0 = m_n[0][7:0];
    it.n1 = m_n[1][7:0];
    it.b0 = m_run[0];
    it.b1 = m_run[1];
    it.k0 = m_done[0];
    it.k1 = m_done[1];
    return it;
  endfunction

  function automatic int inc_of(input int i, input int st);
`ifdef ACUM_STEP_EN
    return st;
`else
    return (i == 0) ? 1 : 4;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_t[i] = 0; m_run[i] = 0; m_done[i] = 0;
    end
  endtask

  // One clock of stimulus; the model predicts the outputs after the next edge.
  task automatic cyc(input bit r, input bit s, input int tg, input bit a, input int st);
    int tgm;
    @(negedge clk);
    #1;
    tgm      = tg & 255;
    rst      = r;
    start    = s;
    target   = tgm[7:0];
    add      = a;
    step_drv = st[7:0];
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        m_n[i] = 0; m_t[i] = 0; m_run[i] = 0; m_done[i] = 0;
      end else if (s) begin
        m_t[i]    = tgm;
        m_n[i]    = 0;
        m_run[i]  = (tgm != 0);
        m_done[i] = (tgm == 0);
      end else if (m_run[i] && a) begin
        if (m_n[i] + inc_of(i, st & 255) >= m_t[i]) begin
          m_n[i]    = m_t[i];
          m_run[i]  = 0;
          m_done[i] = 1;
        end else begin
          m_n[i] = m_n[i] + inc_of(i, st & 255);
        end
      end
    end
    q.push_back(snapshot());
  endtask

  // Assert reset between edges and expect outputs cleared without a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst   = 1'b0;
    start = 1'b0;
    add   = 1'b0;
    #1;
    model_reset();
    aq.push_back(snapshot());
    -> ev_async;
  endtask

  // Monitor: outputs settle after each rising edge; sample on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cycle_no++;
      if (q.size() > 0) compare_item(q.pop_front());
    end
  end

  // Monitor for asynchronous reset events.
  initial begin
    forever begin
      @(ev_async);
      if (aq.size() > 0) compare_item(aq.pop_front());
    end
  end

  initial begin
    int tg;
    rst = 1'b0; start = 1'b0; target = '0; add = 1'b0; step_drv = 8'd1;
    model_reset();

    // Reset state
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Reset mid-run
    cyc(1, 1, 5, 0, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    async_reset();
    cyc(0, 0, 0, 0, 1);

    // Basic count to 3, then an extra add
    cyc(1, 1, 3, 0, 1);
    repeat (4) cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1);

    // Saturation at 10; target wiggles while busy
    cyc(1, 1, 10, 0, 4);
    repeat (4) cyc(1, 0, $urandom_range(0, 255), 1, 4);

    // Overflow boundary at 255
    cyc(1, 1, 255, 0, 1);
    repeat (300) cyc(1, 0, $urandom_range(0, 255), 1, 1);

    // Zero target and restart
    cyc(1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 1, 1);
    cyc(1, 1, 2, 0, 1);
    cyc(1, 0, 0, 0, 1);

    // Priority of start over add
    cyc(1, 1, 5, 0, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 1, 7, 1, 1);
    cyc(1, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 1, 3);
    cyc(1, 0, 0, 0, 3);

    // Randomized run
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        cyc(0, 0, $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 7));
      end else begin
        tg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
        cyc(1, ($urandom_range(0, 9) == 0), tg, $urandom_range(0, 1),
            $urandom_range(0, 7));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", q.size() + aq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
